// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-style PIC control slice: FSM states,
// command decode bit positions, read-select encoding and vector base width.
package pic_pkg;

  // Initialisation / operating state of the command sequencer
  typedef enum logic [2:0] {
    WAIT_ICW1 = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } pic_state_e;

  // Which resolver register an A0=0 read returns
  typedef enum logic {
    SEL_IRR = 1'b0,
    SEL_ISR = 1'b1
  } read_sel_e;

  // Upper five bits of the vector byte come from ICW2
  localparam int VEC_BASE_W = 5;

  // ICW1 / ICW4 bit positions
  localparam int ICW1_ID_BIT   = 4;
  localparam int ICW1_LTIM_BIT = 3;
  localparam int ICW1_SNGL_BIT = 1;
  localparam int ICW1_IC4_BIT  = 0;
  localparam int ICW4_AEOI_BIT = 1;

  // OCW2/OCW3 are told apart by din[4:3] on an A0=0 write
  localparam int         OCW_SEL_HI   = 4;
  localparam int         OCW_SEL_LO   = 3;
  localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
  localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

  // OCW3 read-register command bits
  localparam int OCW3_RR_BIT  = 1;
  localparam int OCW3_RIS_BIT = 0;

  // An A0=0 write with D4 set is always ICW1, whatever the current state
  function automatic logic is_icw1(input logic wr, input logic a0, input logic [7:0] d);
    return wr & ~a0 & d[ICW1_ID_BIT];
  endfunction

endpackage

// File: rtl/pic_inta_sequencer.sv
// INTA handshake: detects inta_n falling edges, counts them, and on the last
// edge of an acknowledge cycle drives the vector byte until inta_n returns high.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int INTA_PULSES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  abort_i,
  input  logic                  inta_n_i,
  input  logic [VEC_BASE_W-1:0] t_base_i,
  input  logic [2:0]            int_vec_i,
  output logic                  fire_o,
  output logic                  vec_oe_o,
  output logic [7:0]            vec_o
);

  localparam int               CNT_W    = (INTA_PULSES > 1) ? $clog2(INTA_PULSES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INTA_PULSES - 1);

  logic             inta_n_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             oe_q, oe_d;
  logic [7:0]       vec_q, vec_d;
  logic             edge_s;

  // An edge only counts in READY, and an ICW1 in the same cycle swallows it
  assign edge_s   = enable_i & ~abort_i & inta_n_q & ~inta_n_i;
  assign fire_o   = edge_s & (cnt_q == LAST_CNT);
  assign vec_oe_o = oe_q;
  assign vec_o    = vec_q;

  // Next pulse count and vector drive: abort clears, final edge loads, rising inta_n releases
  always_comb begin
    cnt_d = cnt_q;
    oe_d  = oe_q;
    vec_d = vec_q;
    if (abort_i) begin
      cnt_d = '0;
      oe_d  = 1'b0;
      vec_d = '0;
    end else begin
      if (oe_q && inta_n_i) begin
        oe_d  = 1'b0;
        vec_d = '0;
      end
      if (fire_o) begin
        cnt_d = '0;
        oe_d  = 1'b1;
        vec_d = {t_base_i, int_vec_i};
      end else if (edge_s) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // inta_n history for edge detection plus the count/vector state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_n_q <= 1'b1;
      cnt_q    <= '0;
      oe_q     <= 1'b0;
      vec_q    <= '0;
    end else begin
      inta_n_q <= inta_n_i;
      cnt_q    <= cnt_d;
      oe_q     <= oe_d;
      vec_q    <= vec_d;
    end
  end

endmodule

// File: rtl/pic_control_logic.sv
// Command sequencer of the 8259A-style PIC: decodes ICW/OCW writes, holds the
// resolver configuration, serves register reads and muxes in the INTA vector.
module pic_control_logic
  import pic_pkg::*;
#(
  parameter int         INTA_PULSES = 2,
  parameter logic [7:0] RESET_IM    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       inta_n,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  input  logic [2:0] int_vec,
  output logic [7:0] im,
  output logic [7:0] operation,
  output logic       op_stb,
  output logic       aeoi,
  output logic       ltim,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       init_done
);

  pic_state_e            state_q, state_d;
  read_sel_e             read_sel_q, read_sel_d;
  logic                  ltim_q, ltim_d;
  logic                  sngl_q, sngl_d;
  logic                  ic4_q, ic4_d;
  logic                  aeoi_q, aeoi_d;
  logic [7:0]            im_q, im_d;
  logic [7:0]            operation_q, operation_d;
  logic                  op_stb_q, op_stb_d;
  logic [VEC_BASE_W-1:0] t_base_q, t_base_d;
  logic                  rd_oe_q, rd_oe_d;
  logic [7:0]            rd_data_q, rd_data_d;

  logic                  wr_icw1;
  logic                  vec_fire;
  logic                  vec_oe;
  logic [7:0]            vec_byte;

  assign wr_icw1 = is_icw1(wr_stb, a0, din);

  pic_inta_sequencer #(
    .INTA_PULSES(INTA_PULSES)
  ) u_inta (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (state_q == READY),
    .abort_i   (wr_icw1),
    .inta_n_i  (inta_n),
    .t_base_i  (t_base_q),
    .int_vec_i (int_vec),
    .fire_o    (vec_fire),
    .vec_oe_o  (vec_oe),
    .vec_o     (vec_byte)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_ICW1;
    else        state_q <= state_d;
  end

  // Init sequence: ICW1 restarts from anywhere, A0=1 writes walk through ICW2..ICW4
  always_comb begin
    state_d = state_q;
    if (wr_icw1) begin
      state_d = WAIT_ICW2;
    end else if (wr_stb && a0) begin
      case (state_q)
        WAIT_ICW2: state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
        WAIT_ICW3: state_d = ic4_q ? WAIT_ICW4 : READY;
        WAIT_ICW4: state_d = READY;
        default:   state_d = state_q;
      endcase
    end
  end

  // FSM outputs and final bus mux (vector drive has priority over read data)
  always_comb begin
    init_done = (state_q == READY);
    dout_oe   = vec_oe | rd_oe_q;
    dout      = vec_oe ? vec_byte : rd_data_q;
  end

  // Register write decode: ICW1 reinitialises, ICWn/OCWn update their fields
  always_comb begin
    ltim_d      = ltim_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    aeoi_d      = aeoi_q;
    im_d        = im_q;
    operation_d = operation_q;
    op_stb_d    = 1'b0;
    t_base_d    = t_base_q;
    read_sel_d  = read_sel_q;
    if (wr_icw1) begin
      ltim_d     = din[ICW1_LTIM_BIT];
      sngl_d     = din[ICW1_SNGL_BIT];
      ic4_d      = din[ICW1_IC4_BIT];
      im_d       = RESET_IM;
      aeoi_d     = 1'b0;
      read_sel_d = SEL_IRR;
    end else if (wr_stb) begin
      case (state_q)
        WAIT_ICW2: if (a0) t_base_d = din[7 -: VEC_BASE_W];
        WAIT_ICW4: if (a0) aeoi_d = din[ICW4_AEOI_BIT];
        READY: begin
          if (a0) begin
            im_d = din;
          end else if (din[OCW_SEL_HI:OCW_SEL_LO] == OCW_SEL_OCW2) begin
            operation_d = din;
            op_stb_d    = 1'b1;
          end else if (din[OCW_SEL_HI:OCW_SEL_LO] == OCW_SEL_OCW3) begin
            if (din[OCW3_RR_BIT]) read_sel_d = din[OCW3_RIS_BIT] ? SEL_ISR : SEL_IRR;
          end
        end
        default: ;
      endcase
    end
  end

  // Register reads: only in READY, and dropped while the vector owns the bus
  always_comb begin
    rd_oe_d   = 1'b0;
    rd_data_d = '0;
    if (rd_stb && (state_q == READY) && !wr_icw1 && !vec_fire && !vec_oe) begin
      rd_oe_d   = 1'b1;
      rd_data_d = a0 ? im_q : ((read_sel_q == SEL_ISR) ? isr : irr);
    end
  end

  // Configuration and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ltim_q      <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      aeoi_q      <= 1'b0;
      im_q        <= RESET_IM;
      operation_q <= '0;
      op_stb_q    <= 1'b0;
      t_base_q    <= '0;
      read_sel_q  <= SEL_IRR;
      rd_oe_q     <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      ltim_q      <= ltim_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      aeoi_q      <= aeoi_d;
      im_q        <= im_d;
      operation_q <= operation_d;
      op_stb_q    <= op_stb_d;
      t_base_q    <= t_base_d;
      read_sel_q  <= read_sel_d;
      rd_oe_q     <= rd_oe_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign im        = im_q;
  assign operation = operation_q;
  assign op_stb    = op_stb_q;
  assign aeoi      = aeoi_q;
  assign ltim      = ltim_q;

endmodule
